// File: rtl/im_fetch_ctrl_pkg.sv
// Instruction-memory map and shared types for the IM fetch controller.
package im_fetch_ctrl_pkg;

  localparam logic [31:0] IM_START_ADDR = 32'h0000_3000;
  localparam logic [31:0] IM_ADDR_LB    = 32'h0000_3000;
  localparam logic [31:0] IM_ADDR_UB    = 32'h0000_AFFF;
  localparam int          IM_AW         = 13;

  // Exception code reported for an instruction-fetch address fault.
  localparam logic [4:0]  EXC_ADEL      = 5'd4;

  localparam logic [3:0]  WE_NONE       = 4'h0;
  localparam logic [3:0]  WE_ALL        = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2,
    LOAD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] data;
  } fetch_resp_t;

  // Word-aligned and inside the inclusive [lb, ub] byte window.
  function automatic logic addr_is_legal(input logic [31:0] a,
                                         input logic [31:0] lb,
                                         input logic [31:0] ub);
    return (a >= lb) && (a <= ub) && (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/im_addr_check.sv
// Combinational IM address legality check and byte-to-word translation.
module im_addr_check
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] START_ADDR = IM_START_ADDR,
  parameter logic [31:0] ADDR_LB    = IM_ADDR_LB,
  parameter logic [31:0] ADDR_UB    = IM_ADDR_UB,
  parameter int          AW         = IM_AW
) (
  input  logic [31:0]   addr,
  output logic          legal,
  output logic [AW-1:0] word_addr
);

  assign legal     = addr_is_legal(addr, ADDR_LB, ADDR_UB);

  // Offset from the IM base, dropped to a word index; the cast keeps only the AW index bits.
  assign word_addr = AW'((addr - START_ADDR) >> 2);

endmodule

// File: rtl/im_fetch_ctrl.sv
// IM fetch controller: arbitrates the single IM port between the IF stage
// and the program loader, screens addresses, and holds fetch responses
// while the IF stage is stalled.
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] START_ADDR = IM_START_ADDR,
  parameter logic [31:0] ADDR_LB    = IM_ADDR_LB,
  parameter logic [31:0] ADDR_UB    = IM_ADDR_UB,
  parameter int          AW         = IM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ready,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_fault,
  input  logic          if_stall,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_ack,
  output logic          ld_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   fetch_cnt
);

  fetch_state_t state;
  logic         resp_fault;
  fetch_resp_t  hold_buf;
  logic         ld_err_q;
  logic [31:0]  fetch_cnt_q;

  logic          if_legal;
  logic [AW-1:0] if_word;
  logic          ld_legal;
  logic [AW-1:0] ld_word;

  logic resp_pending;
  logic consume;
  logic port_free;
  logic accept;
  logic ld_issue;

  im_addr_check #(
    .START_ADDR (START_ADDR),
    .ADDR_LB    (ADDR_LB),
    .ADDR_UB    (ADDR_UB),
    .AW         (AW)
  ) u_if_check (
    .addr      (if_addr),
    .legal     (if_legal),
    .word_addr (if_word)
  );

  im_addr_check #(
    .START_ADDR (START_ADDR),
    .ADDR_LB    (ADDR_LB),
    .ADDR_UB    (ADDR_UB),
    .AW         (AW)
  ) u_ld_check (
    .addr      (ld_addr),
    .legal     (ld_legal),
    .word_addr (ld_word)
  );

  // Handshake: the port is free when idle or when the current response leaves this cycle.
  always_comb begin
    resp_pending = (state == RESP) || (state == HOLD);
    consume      = resp_pending && !if_stall;
    port_free    = (state == IDLE) || consume;
    if_ready     = port_free && !ld_req && !reset;
    accept       = if_req && if_ready;
    ld_issue     = ld_req && port_free && !reset;
  end

  // Response path: RESP forwards the core read data, HOLD replays the captured copy.
  always_comb begin
    if_rvalid = resp_pending;
    if_fault  = 1'b0;
    if_rdata  = '0;
    case (state)
      RESP: begin
        if_fault = resp_fault;
        if_rdata = resp_fault ? 32'h0 : mem_rdata;
      end
      HOLD: begin
        if_fault = hold_buf.fault;
        if_rdata = hold_buf.data;
      end
      default: begin
      end
    endcase
  end

  // Memory port drive: a loader write and a fetch read never share a cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = WE_NONE;
    mem_addr  = if_word;
    mem_wdata = '0;
    if (ld_issue) begin
      mem_addr = ld_word;
      if (ld_legal) begin
        mem_en    = 1'b1;
        mem_we    = WE_ALL;
        mem_wdata = ld_wdata;
      end
    end else if (accept && if_legal) begin
      mem_en = 1'b1;
    end
  end

  assign ld_ack    = (state == LOAD);
  assign ld_err    = (state == LOAD) && ld_err_q;
  assign fetch_cnt = fetch_cnt_q;

  // Controller FSM plus hold buffer and consumed-fetch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      resp_fault  <= 1'b0;
      hold_buf    <= '0;
      ld_err_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      if (consume && !if_fault) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      case (state)
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          if (resp_pending && if_stall) begin
            if (state == RESP) begin
              hold_buf.fault <= if_fault;
              hold_buf.data  <= if_rdata;
            end
            state <= HOLD;
          end else if (accept) begin
            state      <= RESP;
            resp_fault <= !if_legal;
          end else if (ld_issue) begin
            state    <= LOAD;
            ld_err_q <= !ld_legal;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl with a behavioural one-cycle IM core.
module tb_im_fetch_ctrl;
  import im_fetch_ctrl_pkg::*;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ready;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          if_fault;
  logic          if_stall;
  logic          ld_req;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_ack;
  logic          ld_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [31:0]   fetch_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fault;
    logic [31:0] data;
  } resp_exp_t;

  typedef struct {
    logic [31:0]   addr;
    logic          exp_en;
    logic [AW-1:0] exp_word;
    logic          exp_fault;
    logic [31:0]   exp_data;
  } fetch_vec_t;

  resp_exp_t resp_q[$];
  logic      ld_q[$];

  im_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_fault  (if_fault),
    .if_stall  (if_stall),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_err    (ld_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  // IM core model: unwritten word i reads as 32'h1000_0000 | i.
  logic [31:0] mem [0:8191];
  bit          written [0:8191];
  logic [31:0] mem_cur;
  logic [31:0] mem_merged;

  always_comb begin
    mem_cur    = written[mem_addr] ? mem[mem_addr] : (32'h1000_0000 | 32'(mem_addr));
    mem_merged = mem_cur;
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) mem_merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'h0) begin
        mem[mem_addr]     <= mem_merged;
        written[mem_addr] <= 1'b1;
      end
      mem_rdata <= mem_cur;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is consumed or a load is acknowledged.
  resp_exp_t mon_e;
  logic      mon_le;
  always @(negedge clk) begin
    if (!reset) begin
      if (if_rvalid && !if_stall) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got data %h fault %0b expected none", if_rdata, if_fault);
        end else begin
          mon_e = resp_q.pop_front();
          checkOutput("resp_fault", 32'(if_fault), 32'(mon_e.fault));
          checkOutput("resp_data", if_rdata, mon_e.data);
        end
      end
      if (ld_ack) begin
        if (ld_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ld_ack: got ack err %0b expected none", ld_err);
        end else begin
          mon_le = ld_q.pop_front();
          checkOutput("ld_err", 32'(ld_err), 32'(mon_le));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one fetch until accepted; leaves if_req asserted for back-to-back use.
  task automatic applyStimulus(input fetch_vec_t v);
    bit accepted = 1'b0;
    if_req  = 1'b1;
    if_addr = v.addr;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (if_ready) begin
        accepted = 1'b1;
        resp_q.push_back('{fault: v.exp_fault, data: v.exp_data});
        checkOutput("accept_mem_en", 32'(mem_en), 32'(v.exp_en));
        if (v.exp_en) begin
          checkOutput("accept_mem_addr", 32'(mem_addr), 32'(v.exp_word));
          checkOutput("accept_mem_we", 32'(mem_we), 32'h0);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no if_ready for %h expected accept", v.addr);
    end
  endtask

  // Wait (bounded) for the loader acknowledge, then release ld_req.
  task automatic finishLoad();
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = ld_ack;
      @(posedge clk);
      #1;
    end
    ld_req = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ld_ack_timeout: got no ld_ack expected pulse");
    end
  endtask

  fetch_vec_t b2b_vecs [3] = '{
    '{32'h0000_3000, 1'b1, 13'd0, 1'b0, 32'h1000_0000},
    '{32'h0000_3004, 1'b1, 13'd1, 1'b0, 32'h1000_0001},
    '{32'h0000_3008, 1'b1, 13'd2, 1'b0, 32'h1000_0002}
  };

  fetch_vec_t fault_vecs [3] = '{
    '{32'h0000_3002, 1'b0, 13'd0, 1'b1, 32'h0},
    '{32'h0000_2FFC, 1'b0, 13'd0, 1'b1, 32'h0},
    '{32'h0000_B000, 1'b0, 13'd0, 1'b1, 32'h0}
  };

  initial begin
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    if_stall = 1'b0;
    ld_req   = 1'b0;
    ld_addr  = '0;
    ld_wdata = '0;

    tick(1);
    @(negedge clk);
    checkOutput("rst_if_ready", 32'(if_ready), 32'h0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_rvalid", 32'(if_rvalid), 32'h0);
    checkOutput("post_rst_fault", 32'(if_fault), 32'h0);
    checkOutput("post_rst_rdata", if_rdata, 32'h0);
    checkOutput("post_rst_ld_ack", 32'(ld_ack), 32'h0);
    checkOutput("post_rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("post_rst_fetch_cnt", fetch_cnt, 32'h0);
    checkOutput("post_rst_if_ready", 32'(if_ready), 32'h1);
    tick(1);

    $display("[TB] back-to-back fetches");
    for (int i = 0; i < 3; i++) applyStimulus(b2b_vecs[i]);
    if_req = 1'b0;
    tick(3);
    checkOutput("b2b_fetch_cnt", fetch_cnt, 32'd3);

    $display("[TB] faulting fetches");
    for (int i = 0; i < 3; i++) applyStimulus(fault_vecs[i]);
    if_req = 1'b0;
    tick(3);
    checkOutput("fault_fetch_cnt", fetch_cnt, 32'd3);

    applyStimulus('{32'h0000_AFFC, 1'b1, 13'h1FFF, 1'b0, 32'h1000_1FFF});
    if_req = 1'b0;
    tick(3);
    checkOutput("top_word_fetch_cnt", fetch_cnt, 32'd4);

    $display("[TB] stalled fetch");
    if_stall = 1'b1;
    applyStimulus('{32'h0000_3010, 1'b1, 13'd4, 1'b0, 32'h1000_0004});
    if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_rvalid", 32'(if_rvalid), 32'h1);
      checkOutput("stall_rdata", if_rdata, 32'h1000_0004);
      checkOutput("stall_if_ready", 32'(if_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    if_stall = 1'b0;
    tick(3);
    checkOutput("stall_fetch_cnt", fetch_cnt, 32'd5);

    $display("[TB] loader write behind a held response");
    if_stall = 1'b1;
    applyStimulus('{32'h0000_3000, 1'b1, 13'd0, 1'b0, 32'h1000_0000});
    if_req   = 1'b0;
    ld_req   = 1'b1;
    ld_addr  = 32'h0000_3020;
    ld_wdata = 32'hDEAD_BEEF;
    ld_q.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("ld_blocked_mem_en", 32'(mem_en), 32'h0);
      checkOutput("ld_blocked_if_ready", 32'(if_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    if_stall = 1'b0;
    @(negedge clk);
    checkOutput("ld_mem_en", 32'(mem_en), 32'h1);
    checkOutput("ld_mem_we", 32'(mem_we), 32'hF);
    checkOutput("ld_mem_addr", 32'(mem_addr), 32'd8);
    checkOutput("ld_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    finishLoad();
    @(negedge clk);
    checkOutput("ld_ack_single_pulse", 32'(ld_ack), 32'h0);
    tick(1);

    $display("[TB] misaligned loader write");
    ld_req   = 1'b1;
    ld_addr  = 32'h0000_3001;
    ld_wdata = 32'h1234_5678;
    ld_q.push_back(1'b1);
    @(negedge clk);
    checkOutput("ld_bad_mem_en", 32'(mem_en), 32'h0);
    checkOutput("ld_bad_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1;
    finishLoad();
    tick(1);

    applyStimulus('{32'h0000_3020, 1'b1, 13'd8, 1'b0, 32'hDEAD_BEEF});
    if_req = 1'b0;
    tick(3);
    checkOutput("readback_fetch_cnt", fetch_cnt, 32'd7);

    $display("[TB] reset while in RESP");
    if_stall = 1'b1;
    applyStimulus('{32'h0000_3004, 1'b1, 13'd1, 1'b0, 32'h1000_0001});
    if_req = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    checkOutput("rst_resp_if_ready", 32'(if_ready), 32'h0);
    checkOutput("rst_resp_mem_en", 32'(mem_en), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    resp_q.delete();
    @(negedge clk);
    checkOutput("rst_resp_rvalid", 32'(if_rvalid), 32'h0);
    checkOutput("rst_resp_rdata", if_rdata, 32'h0);
    checkOutput("rst_resp_fault", 32'(if_fault), 32'h0);
    checkOutput("rst_resp_fetch_cnt", fetch_cnt, 32'h0);
    tick(1);

    $display("[TB] reset while in HOLD with a pending load");
    applyStimulus('{32'h0000_3008, 1'b1, 13'd2, 1'b0, 32'h1000_0002});
    if_req   = 1'b0;
    tick(1);
    ld_req   = 1'b1;
    ld_addr  = 32'h0000_3024;
    ld_wdata = 32'hCAFE_F00D;
    tick(1);
    @(negedge clk);
    checkOutput("hold_rvalid", 32'(if_rvalid), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    ld_req = 1'b0;
    resp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_hold_ld_ack", 32'(ld_ack), 32'h0);
      checkOutput("rst_hold_rvalid", 32'(if_rvalid), 32'h0);
      @(posedge clk);
      #1;
    end
    checkOutput("rst_hold_fetch_cnt", fetch_cnt, 32'h0);
    if_stall = 1'b0;

    applyStimulus('{32'h0000_3008, 1'b1, 13'd2, 1'b0, 32'h1000_0002});
    if_req = 1'b0;
    tick(3);
    checkOutput("after_rst_fetch_cnt", fetch_cnt, 32'd1);

    for (int c = 0; c < 20 && (resp_q.size() != 0 || ld_q.size() != 0); c++) tick(1);
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'h0);
    checkOutput("ld_queue_drained", 32'(ld_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
Sequences all accesses to the synchronous instruction-memory IP core (one-cycle read latency, 13-bit word address, 4-bit byte write enable). Sits between the IF stage, the program loader (boot/debug download) and the IM core. Arbitrates the single memory port between the two requesters, checks address range and alignment, and holds fetch responses across pipeline stalls. Reports address faults instead of touching memory.

Parameters:
START_ADDR, 32'h0000_3000, byte address mapped to IM word 0
ADDR_LB, 32'h0000_3000, lowest legal byte address (inclusive)
ADDR_UB, 32'h0000_AFFF, highest legal byte address (inclusive)
AW, 13, IM word-address width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  IF stage requests a fetch
if_addr  in  32  fetch byte address (PC)
if_ready  out  1  request accepted this cycle when if_req && if_ready
if_rvalid  out  1  fetch response valid
if_rdata  out  32  instruction word; 0 on fault
if_fault  out  1  response is an address fault (AdEL)
if_stall  in  1  IF cannot consume response this cycle
ld_req  in  1  loader write request (level, held until ld_ack)
ld_addr  in  32  loader byte address
ld_wdata  in  32  loader write data
ld_ack  out  1  one-cycle pulse: write done or rejected
ld_err  out  1  qualifies ld_ack: address illegal, nothing written
mem_en  out  1  IM core enable
mem_we  out  4  IM core byte write enable
mem_addr  out  AW  IM core word address
mem_wdata  out  32  IM core write data
mem_rdata  in  32  IM core read data, valid one cycle after mem_en read
fetch_cnt  out  32  count of completed (consumed) non-fault fetches

Behaviour:
- Legal address: ADDR_LB <= a <= ADDR_UB (unsigned) and a[1:0]==0. Word address = (a - START_ADDR)[AW+1:2].
- Reset: state IDLE; if_ready=0 during reset cycle; if_rvalid, if_fault, ld_ack, ld_err, mem_en, mem_we=0; if_rdata=0; fetch_cnt=0; hold buffer cleared. Reset mid-transaction discards in-flight response and pending load, no ack issued.
- FSM states: IDLE, RESP (response on outputs straight from mem_rdata or fault flag), HOLD (response replayed from buffer), LOAD (ack cycle).
- if_ready = (state==IDLE || (state in {RESP,HOLD} && !if_stall)) && !ld_req.
- Fetch accept, cycle N: legal -> mem_en=1, mem_we=0, mem_addr driven combinationally; illegal -> mem_en=0, fault flag registered. Cycle N+1: state RESP, if_rvalid=1, if_rdata=mem_rdata (legal) or 0 with if_fault=1.
- Response consumed on cycle with if_rvalid && !if_stall; fetch_cnt increments by 1 (wraps at 2^32) when consumed with if_fault=0.
- RESP with if_stall=1: capture if_rdata/if_fault into buffer, go HOLD; outputs stable until consumed.
- Throughput: consume and new accept in same cycle -> next cycle RESP again (1 fetch/cycle back-to-back).
- Consume without new accept -> IDLE, if_rvalid=0 next cycle.
- Loader priority: ld_req blocks new fetch accepts; an outstanding response still completes/holds. Write issued only in a cycle with no accept and no response pending or with response being consumed; legal -> mem_en=1, mem_we=4'hF, mem_wdata=ld_wdata; illegal -> no memory access. Next cycle LOAD: ld_ack=1, ld_err=!legal, then IDLE.
- A fetch to an address written in the same cycle is impossible (loader blocks accepts); a fetch accepted after ld_ack returns new data.
- mem_we is never nonzero while a fetch read is issued.

Decomposition:
- Shared header (IM map): START_ADDR, ADDR_LB, ADDR_UB, AW defaults, AdEL exception code, FSM state encodings.
- Sub-module im_addr_check: combinational legality + word-address translation, instantiated twice (fetch and loader).

Test Plan:
- Reset then fetch 0x3000, 0x3004, 0x3008 back-to-back, no stall -> mem_addr 0,1,2 on cycles N..N+2; if_rvalid cycles N+1..N+3 with core data; fetch_cnt=3.
- Fetch 0x3002 and 0x2FFC and 0xB000 -> no mem_en; if_rvalid next cycle, if_rdata=0, if_fault=1; fetch_cnt unchanged.
- Fetch 0x3010 with if_stall high for 3 cycles -> if_rvalid and if_rdata constant across 4 cycles; if_ready=0 during stall; consumed once, fetch_cnt +1.
- ld_req to 0x3020 data 32'hDEADBEEF while response pending -> response completes first, then mem_we=4'hF, mem_addr=8; ld_ack next cycle, ld_err=0; later fetch 0x3020 returns 32'hDEADBEEF.
- ld_req to 0x3001 -> no mem_en, ld_ack=1 with ld_err=1.
- Assert reset in RESP and in HOLD -> next cycle all outputs 0, no ld_ack, fetch_cnt=0; fetch after reset behaves normally.
